// File: rtl/qpu_ifu_prefetch_pkg.sv
// Shared defaults for the QPU instruction fetch unit: datapath widths and PC step.
package qpu_ifu_prefetch_pkg;
    localparam int QPU_PC_SIZE         = 32;
    localparam int QPU_INSTR_SIZE      = 32;
    localparam int QPU_ITCM_ADDR_WIDTH = 16;
    localparam int QPU_PC_STEP         = 4;
endpackage

// File: rtl/qpu_ifu_pfbuf.sv
// Prefetch buffer: synchronous DEPTH-entry FIFO with a single-cycle clear.
module qpu_ifu_pfbuf #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         clear,
    input  logic [WIDTH-1:0]             din,
    output logic [WIDTH-1:0]             dout,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         empty
);
    localparam int LW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q, wr_d;
    logic [PW-1:0]    rd_q, rd_d;
    logic [LW-1:0]    cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt_q == '0);
    assign level   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & ((cnt_q != LW'(DEPTH)) | do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (clear) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = wr_q + PW'(1);
            if (do_pop)  rd_d = rd_q + PW'(1);
            cnt_d = cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push & ~clear) mem_q[wr_q] <= din;
    end
endmodule

// File: rtl/qpu_ifu_prefetch.sv
// Credit-controlled instruction prefetch between the ITCM ICB port and EXU issue.
module qpu_ifu_prefetch
    import qpu_ifu_prefetch_pkg::*;
#(
    parameter int PC_W    = QPU_PC_SIZE,
    parameter int INSTR_W = QPU_INSTR_SIZE,
    parameter int ADDR_W  = QPU_ITCM_ADDR_WIDTH,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = QPU_PC_STEP
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PC_W-1:0]            pc_rtvec,
    output logic                       icb_cmd_valid,
    input  logic                       icb_cmd_ready,
    output logic [ADDR_W-1:0]          icb_cmd_addr,
    input  logic                       icb_rsp_valid,
    output logic                       icb_rsp_ready,
    input  logic [INSTR_W-1:0]         icb_rsp_rdata,
    output logic                       o_valid,
    input  logic                       o_ready,
    output logic [INSTR_W-1:0]         o_ir,
    output logic [PC_W-1:0]            o_pc,
    input  logic                       flush_req,
    input  logic [PC_W-1:0]            flush_pc,
    output logic                       flush_ack,
    input  logic                       halt_req,
    output logic                       halt_ack,
    output logic [$clog2(DEPTH+1)-1:0] fifo_level
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 1;
    localparam int EW = PC_W + INSTR_W;

    logic              boot_q, boot_d;
    logic [PC_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [PC_W-1:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]     outs_q, outs_d;
    logic [CW-1:0]     disc_q, disc_d;
    logic              halt_ack_q, halt_ack_d;

    logic              cmd_fire;
    logic              rsp_fire;
    logic              rsp_keep;
    logic              pop;
    logic              buf_empty;
    logic [SW-1:0]     credit_used;
    logic [EW-1:0]     buf_dout;

    // Credits count both in-flight requests and buffered entries, so a
    // response always finds a free slot and rsp_ready can stay high.
    assign credit_used   = SW'(outs_q) + SW'(fifo_level);
    assign icb_cmd_valid = ~boot_q & ~halt_req & ~flush_req & (credit_used < SW'(DEPTH));
    assign icb_cmd_addr  = fetch_pc_q[ADDR_W-1:0];
    assign icb_rsp_ready = 1'b1;
    assign flush_ack     = flush_req;
    assign halt_ack      = halt_ack_q;

    assign cmd_fire = icb_cmd_valid & icb_cmd_ready;
    assign rsp_fire = icb_rsp_valid & (outs_q != '0);
    assign rsp_keep = rsp_fire & ~flush_req & (disc_q == '0);
    assign o_valid  = ~buf_empty;
    assign pop      = o_valid & o_ready & ~flush_req;
    assign o_pc     = buf_dout[EW-1:INSTR_W];
    assign o_ir     = buf_dout[INSTR_W-1:0];

    always_comb begin
        boot_d     = 1'b0;
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        disc_d     = disc_q;
        outs_d     = outs_q + CW'(cmd_fire) - CW'(rsp_fire);
        if (boot_q) begin
            fetch_pc_d = pc_rtvec;
            rsp_pc_d   = pc_rtvec;
        end else if (flush_req) begin
            // Everything still in flight after this cycle is stale.
            fetch_pc_d = flush_pc;
            rsp_pc_d   = flush_pc;
            disc_d     = outs_q - CW'(rsp_fire);
        end else begin
            if (cmd_fire) fetch_pc_d = fetch_pc_q + PC_W'(PC_STEP);
            if (rsp_fire && (disc_q != '0)) disc_d = disc_q - CW'(1);
            if (rsp_keep) rsp_pc_d = rsp_pc_q + PC_W'(PC_STEP);
        end
        halt_ack_d = halt_req & (outs_d == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            boot_q     <= 1'b1;
            fetch_pc_q <= '0;
            rsp_pc_q   <= '0;
            outs_q     <= '0;
            disc_q     <= '0;
            halt_ack_q <= 1'b0;
        end else begin
            boot_q     <= boot_d;
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            outs_q     <= outs_d;
            disc_q     <= disc_d;
            halt_ack_q <= halt_ack_d;
        end
    end

    qpu_ifu_pfbuf #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_pfbuf (
        .clk   (clk),
        .rst   (rst),
        .push  (rsp_keep),
        .pop   (pop),
        .clear (flush_req),
        .din   ({rsp_pc_q, icb_rsp_rdata}),
        .dout  (buf_dout),
        .level (fifo_level),
        .empty (buf_empty)
    );
endmodule

// File: tb/tb_qpu_ifu_prefetch.sv
// Bench for qpu_ifu_prefetch: boot table, directed corner sequences and a random run against a queue model.
module tb_qpu_ifu_prefetch;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_rtvec;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_addr;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        o_valid, o_ready;
    logic [31:0] o_ir, o_pc;
    logic        flush_req, flush_ack;
    logic [31:0] flush_pc;
    logic        halt_req, halt_ack;
    logic [2:0]  fifo_level;

    // Narrow-PC instance used for the wrap-around sequence
    logic        c2_valid, c2_ready, r2_valid, r2_ready, o2_valid, f2_ack, h2_ack;
    logic [7:0]  c2_addr, o2_pc, r2_addr;
    logic [31:0] r2_rdata, o2_ir;
    logic [2:0]  lvl2;

    always #5 clk = ~clk;

    qpu_ifu_prefetch dut (
        .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec),
        .icb_cmd_valid(cmd_valid), .icb_cmd_ready(cmd_ready), .icb_cmd_addr(cmd_addr),
        .icb_rsp_valid(rsp_valid), .icb_rsp_ready(rsp_ready), .icb_rsp_rdata(rsp_rdata),
        .o_valid(o_valid), .o_ready(o_ready), .o_ir(o_ir), .o_pc(o_pc),
        .flush_req(flush_req), .flush_pc(flush_pc), .flush_ack(flush_ack),
        .halt_req(halt_req), .halt_ack(halt_ack), .fifo_level(fifo_level)
    );

    qpu_ifu_prefetch #(.PC_W(8), .ADDR_W(8)) dut8 (
        .clk(clk), .rst(rst), .pc_rtvec(pc_rtvec[7:0]),
        .icb_cmd_valid(c2_valid), .icb_cmd_ready(c2_ready), .icb_cmd_addr(c2_addr),
        .icb_rsp_valid(r2_valid), .icb_rsp_ready(r2_ready), .icb_rsp_rdata(r2_rdata),
        .o_valid(o2_valid), .o_ready(o_ready), .o_ir(o2_ir), .o_pc(o2_pc),
        .flush_req(flush_req), .flush_pc(flush_pc[7:0]), .flush_ack(f2_ack),
        .halt_req(halt_req), .halt_ack(h2_ack), .fifo_level(lvl2)
    );

    typedef struct { logic [31:0] pc; int due; bit stale; } req_t;
    typedef struct { bit rdy; bit cv; logic [15:0] addr; bit ov; logic [31:0] pc; } vec_t;

    req_t        mq[$];      // requests the ITCM has accepted, in order
    logic [31:0] bq[$];      // PCs the EXU should see next, in order
    logic [7:0]  w2[$];
    logic [31:0] nf;
    bit          mboot, exp_hack, m_rsp, exp_cv, r2_next, collect2;
    int          cyc, last_due, lat_min, lat_max;
    int          n_chk, n_fail;

    function automatic logic [31:0] ifn(logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cyc_begin();
        m_rsp     = !rst && (mq.size() > 0) && (mq[0].due <= cyc);
        rsp_valid = m_rsp;
        rsp_rdata = m_rsp ? ifn(mq[0].pc[15:0]) : $urandom;
        r2_valid  = r2_next;
        r2_rdata  = {24'h0, r2_addr};
        #1;
        if (rst) begin
            chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
            chk("rst_o_valid", 32'(o_valid), 32'd0);
            chk("rst_halt_ack", 32'(halt_ack), 32'd0);
            chk("rst_fifo_level", 32'(fifo_level), 32'd0);
            chk("rst_flush_ack", 32'(flush_ack), 32'(flush_req));
        end else begin
            exp_cv = !mboot && !halt_req && !flush_req && (mq.size() + bq.size() < 4);
            chk("cmd_valid", 32'(cmd_valid), 32'(exp_cv));
            if (exp_cv) chk("cmd_addr", 32'(cmd_addr), 32'(nf[15:0]));
            chk("rsp_ready", 32'(rsp_ready), 32'd1);
            chk("o_valid", 32'(o_valid), 32'(bq.size() != 0));
            if (bq.size() != 0) begin
                chk("o_pc", o_pc, bq[0]);
                chk("o_ir", o_ir, ifn(bq[0][15:0]));
            end
            chk("fifo_level", 32'(fifo_level), 32'(bq.size()));
            chk("flush_ack", 32'(flush_ack), 32'(flush_req));
            chk("halt_ack", 32'(halt_ack), 32'(exp_hack));
        end
    endtask

    task automatic cyc_end();
        req_t e;
        int   d;
        e = '{pc: 32'h0, due: 0, stale: 1'b0};
        if (collect2 && o2_valid && o_ready && !flush_req && !rst) w2.push_back(o2_pc);
        r2_next = !rst && c2_valid && c2_ready;
        r2_addr = c2_addr;
        if (rst) begin
            mq.delete(); bq.delete();
            mboot = 1; nf = 32'h0; exp_hack = 0; last_due = cyc;
        end else begin
            if (mboot) begin
                nf    = pc_rtvec;
                mboot = 0;
            end else begin
                if (m_rsp) e = mq.pop_front();
                if (flush_req) begin
                    bq.delete();
                    foreach (mq[i]) mq[i].stale = 1'b1;
                    nf = flush_pc;
                end else begin
                    if (bq.size() != 0 && o_ready) void'(bq.pop_front());
                    if (m_rsp && !e.stale) bq.push_back(e.pc);
                    if (exp_cv && cmd_ready) begin
                        d = cyc + $urandom_range(lat_max, lat_min);
                        if (d <= last_due) d = last_due + 1;
                        last_due = d;
                        mq.push_back('{pc: nf, due: d, stale: 1'b0});
                        nf = nf + 32'd4;
                    end
                end
            end
            exp_hack = halt_req && (mq.size() == 0);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run(int n);
        for (int k = 0; k < n; k++) begin
            cyc_begin();
            cyc_end();
        end
    endtask

    task automatic do_reset(logic [31:0] vec);
        rst = 1'b1; pc_rtvec = vec; flush_req = 1'b0; halt_req = 1'b0;
        run(2);
        rst = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        vec_t        bt[6];
        logic [7:0]  wexp[3];
        int          cnt, last_rsp, ack_cyc;
        bit          got;

        bt[0] = '{1'b1, 1'b0, 16'h0000, 1'b0, 32'h0};
        bt[1] = '{1'b1, 1'b1, 16'h0100, 1'b0, 32'h0};
        bt[2] = '{1'b1, 1'b1, 16'h0104, 1'b0, 32'h0};
        bt[3] = '{1'b1, 1'b1, 16'h0108, 1'b1, 32'h100};
        bt[4] = '{1'b1, 1'b1, 16'h010C, 1'b1, 32'h104};
        bt[5] = '{1'b1, 1'b1, 16'h0110, 1'b1, 32'h108};
        wexp[0] = 8'hFC; wexp[1] = 8'h00; wexp[2] = 8'h04;

        n_chk = 0; n_fail = 0; cyc = 0; last_due = 0; collect2 = 0; r2_next = 0; r2_addr = 8'h0;
        rst = 1'b1; pc_rtvec = 32'h0; cmd_ready = 1'b1; c2_ready = 1'b1; o_ready = 1'b1;
        flush_req = 1'b0; flush_pc = 32'h0; halt_req = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'h0;
        mboot = 1; nf = 0; exp_hack = 0; lat_min = 1; lat_max = 1;
        @(negedge clk);

        // Boot from 0x100 with a zero-wait ITCM
        do_reset(32'h100);
        for (int i = 0; i < 6; i++) begin
            o_ready = bt[i].rdy;
            cyc_begin();
            chk("boot_cmd_valid", 32'(cmd_valid), 32'(bt[i].cv));
            if (bt[i].cv) chk("boot_cmd_addr", 32'(cmd_addr), 32'(bt[i].addr));
            chk("boot_o_valid", 32'(o_valid), 32'(bt[i].ov));
            if (bt[i].ov) chk("boot_o_pc", o_pc, bt[i].pc);
            cyc_end();
        end
        run(10);

        // Back-pressure: exactly DEPTH commands, then issue stays off
        do_reset(32'h400);
        o_ready = 1'b0; cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cyc_begin();
            if (cmd_valid && cmd_ready) cnt++;
            cyc_end();
        end
        chk("bp_cmd_count", 32'(cnt), 32'd4);
        o_ready = 1'b1;
        cyc_begin();
        chk("bp_level_full", 32'(fifo_level), 32'd4);
        chk("bp_no_issue_on_pop", 32'(cmd_valid), 32'd0);
        cyc_end();
        cyc_begin();
        chk("bp_issue_resumes", 32'(cmd_valid), 32'd1);
        cyc_end();
        run(20);

        // Flush with two requests in flight on a slow ITCM
        lat_min = 3; lat_max = 3;
        do_reset(32'h100);
        run(1);
        run(2);
        cmd_ready = 1'b0;
        run(1);
        flush_req = 1'b1; flush_pc = 32'h200;
        cyc_begin();
        chk("fl2_ack", 32'(flush_ack), 32'd1);
        cyc_end();
        flush_req = 1'b0; cmd_ready = 1'b1; got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            cyc_begin();
            if (o_valid) begin
                chk("fl2_first_pc", o_pc, 32'h200);
                got = 1;
            end
            cyc_end();
        end
        chk("fl2_wait", 32'(got), 32'd1);
        run(10);

        // Flush colliding with a response and a pop
        lat_min = 1; lat_max = 1;
        do_reset(32'h100);
        run(8);
        flush_req = 1'b1; flush_pc = 32'h300;
        cyc_begin();
        chk("col_pop_pending", 32'(o_valid), 32'd1);
        cyc_end();
        flush_req = 1'b0;
        cyc_begin();
        chk("col_level", 32'(fifo_level), 32'd0);
        chk("col_o_valid", 32'(o_valid), 32'd0);
        cyc_end();
        run(10);

        // Halt with three outstanding requests
        lat_min = 4; lat_max = 4;
        do_reset(32'h100);
        o_ready = 1'b0;
        run(4);
        halt_req = 1'b1; cnt = 0; last_rsp = -100; ack_cyc = -1;
        for (int i = 0; i < 12; i++) begin
            cyc_begin();
            if (cmd_valid) cnt++;
            if (rsp_valid) last_rsp = cyc;
            if (halt_ack && ack_cyc < 0) ack_cyc = cyc;
            cyc_end();
        end
        chk("halt_no_cmd", 32'(cnt), 32'd0);
        chk("halt_ack_delay", 32'(ack_cyc - last_rsp), 32'd1);
        cyc_begin();
        chk("halt_level", 32'(fifo_level), 32'd3);
        cyc_end();
        halt_req = 1'b0; o_ready = 1'b1;
        run(12);

        // PC wrap on the 8-bit instance
        lat_min = 1; lat_max = 1;
        do_reset(32'h100);
        run(6);
        collect2 = 1; w2.delete();
        flush_req = 1'b1; flush_pc = 32'hFC;
        run(1);
        flush_req = 1'b0;
        run(8);
        collect2 = 0;
        chk("wrap_count", 32'(w2.size() >= 3), 32'd1);
        for (int i = 0; i < 3; i++)
            if (i < w2.size()) chk("wrap_pc", 32'(w2[i]), 32'(wexp[i]));

        // Random traffic with variable latency, flushes, halts and a mid-run reset
        lat_min = 1; lat_max = 3;
        do_reset($urandom & 32'hFFFF_FFFC);
        for (int i = 0; i < 1500; i++) begin
            o_ready   = ($urandom % 4) != 0;
            cmd_ready = ($urandom % 5) != 0;
            flush_req = !mboot && (($urandom % 40) == 0);
            flush_pc  = $urandom & 32'hFFFF_FFFC;
            if (($urandom % 60) == 0) halt_req = ~halt_req;
            if (i == 700) begin
                do_reset($urandom & 32'hFFFF_FFFC);
            end else begin
                cyc_begin();
                cyc_end();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
